dma_burst_split: RTL and testbench
==================================

DMA_BURST_SPLIT -- requirements
Module: dma_burst_split

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width.
REQ-002 Parameter DATA_W, default 32, word width in bits; power of two, 8 or more.
REQ-003 Parameter CNT_W, default 16, transfer word-count width.
REQ-004 Parameter MAX_BEATS, default 16, maximum beats per burst; range 1..256.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 start  in  1  one-cycle request to begin a transfer.
REQ-008 start_addr  in  ADDR_W  transfer byte start address.
REQ-009 xfer_words  in  CNT_W  transfer length in words.
REQ-010 busy  out  1  transfer in progress.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 err  out  1  sticky error flag, cleared by the next accepted start.
REQ-013 eng_valid  out  1  burst request to the read burst engine.
REQ-014 eng_addr  out  ADDR_W  burst byte address.
REQ-015 eng_len  out  8  burst beats minus one.
REQ-016 eng_idle  in  1  engine is idle and can accept a request.
REQ-017 eng_ready  in  1  one beat delivered this cycle.
REQ-018 eng_rdata  in  DATA_W  beat data.
REQ-019 eng_error  in  1  engine burst-termination error, registered by the engine.
REQ-020 out_valid  out  1  beat valid to the consumer; out_data  out  DATA_W  beat data.
REQ-021 words_done  out  CNT_W  beats delivered in the current transfer.

Function
REQ-022 The FSM SHALL have five states: IDLE, CALC, BURST, NEXT, DONE.
REQ-023 IDLE: start with xfer_words=0 SHALL go to DONE with err=0.
REQ-024 IDLE: start with start_addr not DATA_W/8-aligned SHALL go to DONE with err=1.
REQ-025 IDLE: any other start SHALL latch address and remaining count, clear err and words_done, and go to CALC.
REQ-026 start outside IDLE SHALL be ignored.
REQ-027 CALC: beats SHALL be min(remaining, MAX_BEATS, (4096 - addr[11:0]) / (DATA_W/8)).
REQ-028 CALC: eng_len SHALL be registered as beats-1; move to BURST only when eng_idle=1.
REQ-029 eng_valid SHALL be high exactly in BURST.
REQ-030 eng_addr and eng_len SHALL be stable throughout BURST.
REQ-031 BURST: each eng_ready SHALL increment the beat counter and words_done.
REQ-032 BURST: on the beat where eng_ready=1 and beat count = eng_len, SHALL go to NEXT.
REQ-033 NEXT: addr SHALL advance by beats*(DATA_W/8) and remaining SHALL decrease by beats.
REQ-034 NEXT: eng_error=1 SHALL set err.
REQ-035 NEXT: SHALL go to DONE if remaining=0, otherwise to CALC.
REQ-036 DONE: done=1 for one cycle, then IDLE.
REQ-037 busy SHALL be high in CALC, BURST and NEXT.
REQ-038 out_valid SHALL equal eng_ready and BURST; out_data SHALL equal eng_rdata combinationally.
REQ-039 eng_ready outside BURST SHALL be ignored.
REQ-040 Address arithmetic SHALL wrap modulo 2^ADDR_W.

Reset
REQ-041 rst SHALL force IDLE and clear busy, done, err, eng_valid, eng_len, eng_addr, words_done and all counters, including mid-burst.

Configuration
REQ-042 With DMA_SPLIT_ABORT_EN defined, NEXT with eng_error=1 SHALL go to DONE regardless of remaining.
REQ-043 Without DMA_SPLIT_ABORT_EN, all remaining bursts SHALL still be issued and err SHALL remain set.

Verification (DATA_W=32, MAX_BEATS=16)
REQ-044 start_addr 0x1000, xfer_words 16 -> one burst, eng_addr 0x1000, eng_len 15; done after 16th beat; words_done=16.
REQ-045 start_addr 0x0, xfer_words 40 -> bursts (0x0,15), (0x40,15), (0x80,7); eng_valid low between bursts.
REQ-046 start_addr 0xFF8, xfer_words 8 -> bursts (0xFF8,1), (0x1000,5).
REQ-047 xfer_words 0 -> done 2 cycles after start, eng_valid never high, err=0; start_addr 0x2 -> same with err=1.
REQ-048 eng_error=1 after burst 1 of 3 -> with DMA_SPLIT_ABORT_EN: done after 1 burst, err=1; without: 3 bursts, err=1.
REQ-049 rst pulse mid-burst 2 of 3 -> eng_valid=0 immediately, busy=0; a new start then runs correctly from IDLE.

Source files
------------

// File: rtl/dma_burst_split_if.sv
// dma_burst_split_if
// Bundles the request/beat signals between the burst splitter and the read
// burst engine.
//   master : splitter side  (drives eng_valid/eng_addr/eng_len)
//   slave  : engine side    (drives eng_idle/eng_ready/eng_rdata/eng_error)
// Parameters: ADDR_W byte-address width, DATA_W beat width.
interface dma_burst_split_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              eng_valid;
  logic [ADDR_W-1:0] eng_addr;
  logic [7:0]        eng_len;
  logic              eng_idle;
  logic              eng_ready;
  logic [DATA_W-1:0] eng_rdata;
  logic              eng_error;

  modport master (
    output eng_valid, eng_addr, eng_len,
    input  eng_idle, eng_ready, eng_rdata, eng_error
  );

  modport slave (
    input  eng_valid, eng_addr, eng_len,
    output eng_idle, eng_ready, eng_rdata, eng_error
  );
endinterface

// File: rtl/dma_burst_split.sv
// dma_burst_split
// Splits a word-count DMA read transfer into engine bursts that never exceed
// MAX_BEATS beats and never cross a 4 KiB address page. Beats returned by the
// engine are forwarded to the consumer unchanged.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   i_start             one-cycle transfer request (ignored unless idle)
//   i_start_addr        transfer byte start address
//   i_xfer_words        transfer length in words
//   o_busy              transfer in progress (CALC/BURST/NEXT)
//   o_done              one-cycle completion pulse, the cycle after DONE
//   o_err               sticky error, cleared by the next accepted start
//   o_words_done        beats delivered in the current transfer
//   eng                 burst engine interface (master modport)
//   o_out_valid         beat valid to consumer
//   o_out_data          beat data to consumer
//
// Build option: define DMA_SPLIT_ABORT_EN to stop issuing bursts after an
// engine error; by default the remaining bursts are still issued.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | size next burst, wait for engine idle
// BURST | request held, counting beats
// NEXT  | advance address/remaining, sample engine error
// DONE  | raise done, return to IDLE
module dma_burst_split #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 16,
  parameter int MAX_BEATS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_start_addr,
  input  logic [CNT_W-1:0]  i_xfer_words,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [CNT_W-1:0]  o_words_done,
  dma_burst_split_if.master eng,
  output logic              o_out_valid,
  output logic [DATA_W-1:0] o_out_data
);
  localparam int BYTES = DATA_W / 8;
  localparam int LSB   = $clog2(BYTES);
  // Internal beat arithmetic must hold both the word count and a page's worth
  // of words, whichever is wider.
  localparam int MW    = (CNT_W > 13) ? CNT_W : 13;

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_BURST, S_NEXT, S_DONE} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [MW-1:0]     r_remain;
  logic [MW-1:0]     r_beats;
  logic [7:0]        r_beat_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [CNT_W-1:0]  r_words_done;
  logic              r_eng_valid;
  logic [ADDR_W-1:0] r_eng_addr;
  logic [7:0]        r_eng_len;

  logic [12:0]       w_page_bytes;
  logic [MW-1:0]     w_page_words;
  logic [MW-1:0]     w_max;
  logic [MW-1:0]     w_b1;
  logic [MW-1:0]     w_beats;
  logic [MW-1:0]     w_rem_next;
  logic [ADDR_W-1:0] w_step;
  logic              w_misalign;
  logic              w_last;

  // Bytes left before the next 4 KiB boundary (1..4096), then in words.
  assign w_page_bytes = 13'd4096 - {1'b0, r_addr[11:0]};
  assign w_page_words = MW'(w_page_bytes >> LSB);
  assign w_max        = MW'(MAX_BEATS);
  assign w_b1         = (r_remain < w_max) ? r_remain : w_max;
  assign w_beats      = (w_b1 < w_page_words) ? w_b1 : w_page_words;

  assign w_rem_next   = r_remain - r_beats;
  assign w_step       = ADDR_W'(r_beats) << LSB;
  assign w_misalign   = (i_start_addr & ADDR_W'(BYTES - 1)) != '0;

`ifdef DMA_SPLIT_ABORT_EN
  assign w_last = (w_rem_next == '0) || eng.eng_error;
`else
  assign w_last = (w_rem_next == '0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_remain     <= '0;
      r_beats      <= '0;
      r_beat_cnt   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_words_done <= '0;
      r_eng_valid  <= 1'b0;
      r_eng_addr   <= '0;
      r_eng_len    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_words_done <= '0;
            if (i_xfer_words == '0) begin
              r_err   <= 1'b0;
              r_state <= S_DONE;
            end else if (w_misalign) begin
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_addr   <= i_start_addr;
              r_remain <= MW'(i_xfer_words);
              r_err    <= 1'b0;
              r_busy   <= 1'b1;
              r_state  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          // Address and remaining are frozen here, so re-registering each
          // cycle while waiting for the engine keeps the request constant.
          r_eng_addr <= r_addr;
          r_eng_len  <= w_beats[7:0] - 8'd1;
          r_beats    <= w_beats;
          r_beat_cnt <= '0;
          if (eng.eng_idle) begin
            r_eng_valid <= 1'b1;
            r_state     <= S_BURST;
          end
        end
        S_BURST: begin
          if (eng.eng_ready) begin
            r_beat_cnt   <= r_beat_cnt + 8'd1;
            r_words_done <= r_words_done + CNT_W'(1);
            if (r_beat_cnt == r_eng_len) begin
              r_eng_valid <= 1'b0;
              r_state     <= S_NEXT;
            end
          end
        end
        S_NEXT: begin
          r_addr   <= r_addr + w_step;
          r_remain <= w_rem_next;
          if (eng.eng_error) r_err <= 1'b1;
          if (w_last) begin
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_state <= S_CALC;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign eng.eng_valid = r_eng_valid;
  assign eng.eng_addr  = r_eng_addr;
  assign eng.eng_len   = r_eng_len;

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_err         = r_err;
  assign o_words_done  = r_words_done;
  assign o_out_valid   = eng.eng_ready && (r_state == S_BURST);
  assign o_out_data    = eng.eng_rdata;
endmodule

// File: tb/tb_dma_burst_split.sv
module tb_dma_burst_split;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int MB = 16;
  localparam int BIG = 32'h7fff0000;

  typedef struct {
    logic [31:0] a;
    int          len;
  } burst_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [CW-1:0] xfer_words;
  logic          busy, done, err;
  logic [CW-1:0] words_done;
  logic          out_valid;
  logic [DW-1:0] out_data;

  always #5 clk = ~clk;

  dma_burst_split_if #(.ADDR_W(AW), .DATA_W(DW)) eng_if ();

  dma_burst_split #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW), .MAX_BEATS(MB)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (start),
    .i_start_addr (start_addr),
    .i_xfer_words (xfer_words),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err),
    .o_words_done (words_done),
    .eng          (eng_if),
    .o_out_valid  (out_valid),
    .o_out_data   (out_data)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference burst plan: plain arithmetic from the splitting rules.
  burst_t plan_q[$];
  function automatic void build_plan(logic [31:0] a, int n);
    plan_q.delete();
    while (n > 0) begin
      int room;
      int b;
      room = (4096 - int'(a[11:0])) / (DW / 8);
      b = n;
      if (b > MB) b = MB;
      if (b > room) b = room;
      plan_q.push_back('{a, b - 1});
      a = a + 32'(b * (DW / 8));
      n = n - b;
    end
  endfunction

  // ---------------- engine stand-in ----------------
  int fail_burst = -1;
  int eng_bidx   = 0;

  initial begin
    int  bcnt;
    bit  nxt;
    bit  fail_now;
    bcnt = 0; nxt = 0; fail_now = 0;
    eng_if.eng_idle  = 1'b1;
    eng_if.eng_ready = 1'b0;
    eng_if.eng_rdata = '0;
    eng_if.eng_error = 1'b0;
    forever begin
      @(negedge clk);
      nxt = 0;
      if (rst) begin
        bcnt = 0;
      end else if (eng_if.eng_valid && eng_if.eng_ready) begin
        bcnt++;
        if (bcnt == int'(eng_if.eng_len) + 1) begin
          nxt      = 1;
          fail_now = (eng_bidx == fail_burst);
          eng_bidx++;
          bcnt = 0;
        end
      end
      @(posedge clk);
      #1;
      eng_if.eng_ready = ($urandom % 4) != 0;
      eng_if.eng_idle  = ($urandom % 5) != 0;
      eng_if.eng_rdata = $urandom;
      // Error is meaningful only in the cycle right after a burst's last
      // beat; elsewhere it is noise that must be ignored.
      eng_if.eng_error = nxt ? fail_now : (($urandom % 8) == 0);
    end
  end

  // ---------------- reference model and per-cycle compare ----------------
  int     cyc = 0;
  int     done_at, start_c, expect_valid_at, calc_from, last_beat;
  int     err_at, wd_clr_at, wd, beats;
  bit     waiting, exp_valid, err_exp, err_val, prev_dut_valid;
  burst_t exp_q[$];
  burst_t obs_q[$];
  burst_t cur;

  always @(negedge clk) begin
    if (rst) begin
      done_at = -5; start_c = -5; expect_valid_at = -1; calc_from = 0;
      last_beat = -10; err_at = -1; wd_clr_at = -1; wd = 0; beats = 0;
      waiting = 0; exp_valid = 0; err_exp = 0; err_val = 0; prev_dut_valid = 0;
      exp_q.delete();
      cur = '{32'h0, 0};
    end else begin
      if (cyc == err_at) err_exp = err_val;
      if (cyc == wd_clr_at) wd = 0;

      if (cyc == last_beat + 1) begin
        bit stop;
        if (eng_if.eng_error) begin
          err_at  = cyc + 1;
          err_val = 1;
        end
        stop = (exp_q.size() == 0);
`ifdef DMA_SPLIT_ABORT_EN
        if (eng_if.eng_error) begin
          stop = 1;
          exp_q.delete();
        end
`endif
        if (stop) done_at = cyc + 2;
        else begin
          waiting   = 1;
          calc_from = cyc + 1;
        end
      end

      if (waiting && cyc >= calc_from && eng_if.eng_idle) begin
        expect_valid_at = cyc + 1;
        waiting = 0;
      end

      if (cyc == expect_valid_at) begin
        exp_valid = 1;
        beats = 0;
        if (exp_q.size() > 0) cur = exp_q.pop_front();
      end

      if (eng_if.eng_valid && !prev_dut_valid)
        obs_q.push_back('{eng_if.eng_addr, int'(eng_if.eng_len)});
      prev_dut_valid = eng_if.eng_valid;

      chk("eng_valid", eng_if.eng_valid, exp_valid);
      if (exp_valid) begin
        chk("eng_addr", eng_if.eng_addr, cur.a);
        chk("eng_len", eng_if.eng_len, cur.len);
      end
      chk("out_valid", out_valid, exp_valid && eng_if.eng_ready);
      if (exp_valid && eng_if.eng_ready) chk("out_data", out_data, eng_if.eng_rdata);
      chk("words_done", words_done, wd);
      chk("busy", busy, (cyc > start_c) && (cyc < done_at - 1));
      chk("done", done, cyc == done_at);
      chk("err", err, err_exp);

      if (exp_valid && eng_if.eng_ready) begin
        wd++;
        beats++;
        if (beats == cur.len + 1) begin
          exp_valid = 0;
          last_beat = cyc;
        end
      end

      if (start && cyc >= done_at) begin
        start_c   = cyc;
        wd_clr_at = cyc + 1;
        err_at    = cyc + 1;
        if (xfer_words == '0) begin
          err_val = 0;
          done_at = cyc + 2;
        end else if (start_addr[1:0] != 2'b00) begin
          err_val = 1;
          done_at = cyc + 2;
        end else begin
          err_val = 0;
          done_at = BIG;
          build_plan(start_addr, int'(xfer_words));
          exp_q     = plan_q;
          waiting   = 1;
          calc_from = cyc + 1;
        end
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic run_xfer(input logic [31:0] a, input int n, input int fb,
                          input int extra_at, output int lat);
    bit got;
    @(posedge clk);
    #1;
    start = 1'b1; start_addr = a; xfer_words = n[15:0];
    fail_burst = fb; eng_bidx = 0;
    obs_q.delete();
    @(negedge clk);
    @(posedge clk);
    #1;
    start = 1'b0;
    got = 0;
    lat = -1;
    for (int i = 1; i <= 3000 && !got; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        lat = i;
      end else if (i == extra_at) begin
        // A second request while busy must be ignored.
        @(posedge clk);
        #1;
        start = 1'b1; start_addr = 32'h100; xfer_words = 16'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    end
    chk("done_seen", got, 1'b1);
  endtask

  initial begin
    int lat;
    rst = 1'b1; start = 1'b0; start_addr = '0; xfer_words = '0;
    #1;
    if (0) ;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_eng_valid", eng_if.eng_valid, 1'b0);
    chk("rst_eng_len", eng_if.eng_len, 8'd0);
    chk("rst_eng_addr", eng_if.eng_addr, 32'd0);
    chk("rst_words_done", words_done, 16'd0);
    @(posedge clk);
    #3 rst = 1'b0;

    // Pin the reference plan against hand-worked splits.
    build_plan(32'h0, 40);
    chk("plan40_n", plan_q.size(), 3);
    chk("plan40_b2a", plan_q[2].a, 32'h80);
    chk("plan40_b2l", plan_q[2].len, 7);
    build_plan(32'hFF8, 8);
    chk("planFF8_b0l", plan_q[0].len, 1);
    chk("planFF8_b1a", plan_q[1].a, 32'h1000);
    chk("planFF8_b1l", plan_q[1].len, 5);

    run_xfer(32'h1000, 16, -1, -1, lat);
    chk("single_n", obs_q.size(), 1);
    if (obs_q.size() == 1) begin
      chk("single_addr", obs_q[0].a, 32'h1000);
      chk("single_len", obs_q[0].len, 15);
    end
    chk("single_words_done", words_done, 16'd16);

    run_xfer(32'h0, 40, -1, -1, lat);
    chk("three_n", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      chk("three_a0", obs_q[0].a, 32'h0);
      chk("three_l0", obs_q[0].len, 15);
      chk("three_a1", obs_q[1].a, 32'h40);
      chk("three_l1", obs_q[1].len, 15);
      chk("three_a2", obs_q[2].a, 32'h80);
      chk("three_l2", obs_q[2].len, 7);
    end
    chk("three_err", err, 1'b0);

    run_xfer(32'hFF8, 8, -1, -1, lat);
    chk("page_n", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      chk("page_a0", obs_q[0].a, 32'hFF8);
      chk("page_l0", obs_q[0].len, 1);
      chk("page_a1", obs_q[1].a, 32'h1000);
      chk("page_l1", obs_q[1].len, 5);
    end

    run_xfer(32'hFFFF_FFF0, 20, -1, -1, lat);
    chk("wrap_n", obs_q.size(), 2);
    if (obs_q.size() == 2) chk("wrap_a1", obs_q[1].a, 32'h0);

    run_xfer(32'h40, 0, -1, -1, lat);
    chk("zero_lat", lat, 2);
    chk("zero_err", err, 1'b0);
    chk("zero_bursts", obs_q.size(), 0);

    run_xfer(32'h2, 5, -1, -1, lat);
    chk("misalign_lat", lat, 2);
    chk("misalign_err", err, 1'b1);
    chk("misalign_bursts", obs_q.size(), 0);

    run_xfer(32'h0, 40, 0, -1, lat);
`ifdef DMA_SPLIT_ABORT_EN
    chk("abort_n", obs_q.size(), 1);
`else
    chk("noabort_n", obs_q.size(), 3);
`endif
    chk("engerr_err", err, 1'b1);

    run_xfer(32'h200, 40, -1, 10, lat);
    chk("ignored_start_n", obs_q.size(), 3);
    chk("ignored_start_err", err, 1'b0);

    // Reset in the middle of burst 2 of 3.
    @(posedge clk);
    #1;
    start = 1'b1; start_addr = 32'h0; xfer_words = 16'd40;
    fail_burst = -1; eng_bidx = 0; obs_q.delete();
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 500 && obs_q.size() < 2; i++) @(negedge clk);
    chk("midrst_reached", obs_q.size(), 2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", eng_if.eng_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_wd", words_done, 16'd0);
    @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    run_xfer(32'h1000, 16, -1, -1, lat);
    chk("after_rst_n", obs_q.size(), 1);
    chk("after_rst_wd", words_done, 16'd16);

    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      int n;
      int fb;
      a = $urandom & ~32'h3;
      if ($urandom % 2 == 0) a = (a & ~32'hFFF) | (32'd4096 - 32'($urandom_range(1, 24) * 4));
      if ($urandom % 10 == 0) a = a | 32'($urandom_range(1, 3));
      n = ($urandom % 10 == 0) ? 0 : $urandom_range(1, 70);
      fb = ($urandom % 3 == 0) ? $urandom_range(0, 3) : -1;
      run_xfer(a, n, fb, -1, lat);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end
endmodule
